// File: rtl/opb_register_bank_ppc2simulink.sv
// opb_register_bank_ppc2simulink
// OPB slave holding a bank of C_NUM_REGS 32-bit PPC-to-fabric registers.
// Bus writes land in shadow registers with byte-lane granularity. A COMMIT
// write copies every shadow word to the fabric outputs on the same cycle, so
// multi-word tables always change coherently on the fabric side.
// Optional build macro: REGBANK_READBACK_EN
//   defined   -> register reads return the shadow value, STATUS is readable
//   undefined -> every read returns 0 (reads are still acknowledged)
module opb_register_bank_ppc2simulink #(
  parameter logic [31:0] C_BASEADDR    = 32'h0000_0000,
  parameter logic [31:0] C_HIGHADDR    = 32'h0000_00FF,
  parameter int          C_NUM_REGS    = 8,
  parameter logic [31:0] C_RESET_VAL   = 32'h0000_0000,
  parameter int          C_AUTO_COMMIT = 0
) (
  input  logic                      OPB_Clk,
  input  logic                      OPB_Rst_n,
  input  logic [0:31]               OPB_ABus,
  input  logic [0:3]                OPB_BE,
  input  logic [0:31]               OPB_DBus,
  input  logic                      OPB_RNW,
  input  logic                      OPB_select,
  input  logic                      OPB_seqAddr,
  output logic [0:31]               Sl_DBus,
  output logic                      Sl_xferAck,
  output logic                      Sl_errAck,
  output logic                      Sl_retry,
  output logic                      Sl_toutSup,
  output logic [C_NUM_REGS*32-1:0]  user_data_out,
  output logic                      user_load,
  output logic [15:0]               user_commit_cnt
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACK  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam logic [29:0] COMMIT_IDX  = 30'(C_NUM_REGS);
  localparam logic [29:0] STATUS_IDX  = 30'(C_NUM_REGS + 1);
  localparam logic [31:0] WINDOW_SPAN = C_HIGHADDR - C_BASEADDR;

  // Bus fields re-expressed with bit 31 as the most significant bit, so the
  // OPB big-endian lane 0 (BE[0], DBus[0:7]) becomes be[3] / wdata[31:24].
  logic [31:0] abus;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [31:0] offset;
  logic [29:0] word_idx;
  logic        in_window;
  logic        start;
  logic        wr_start;
  logic        commit_hit;
  logic [31:0] lane_mask;
  logic [31:0] rd_data;

  logic [1:0]                  state;
  logic                        ack_q;
  logic [31:0]                 dbus_q;
  logic [31:0]                 shadow [C_NUM_REGS];
  logic [C_NUM_REGS*32-1:0]    active_q;
  logic                        commit_pend;
  logic [C_NUM_REGS-1:0]       auto_mask;
  logic                        load_q;
  logic [15:0]                 cnt_q;

  assign abus  = OPB_ABus;
  assign wdata = OPB_DBus;
  assign be    = OPB_BE;

  // Subtracting the base first lets one unsigned compare cover the whole
  // window: addresses below the base wrap to huge offsets and fall outside.
  assign offset     = abus - C_BASEADDR;
  assign word_idx   = offset[31:2];
  assign in_window  = (offset <= WINDOW_SPAN);
  assign start      = (state == ST_IDLE) && OPB_select && in_window;
  assign wr_start   = start && !OPB_RNW;
  assign commit_hit = wr_start && (word_idx == COMMIT_IDX) && wdata[0];

  // Expand the byte enables into a per-bit write mask
  always_comb begin
    lane_mask = 32'h0;
    for (int j = 0; j < 4; j++) begin
      lane_mask[8*j +: 8] = {8{be[j]}};
    end
  end

  // Select read data for the addressed word; without readback it stays zero
  always_comb begin
    rd_data = 32'h0;
`ifdef REGBANK_READBACK_EN
    for (int i = 0; i < C_NUM_REGS; i++) begin
      if (word_idx == 30'(i)) begin
        rd_data = shadow[i];
      end
    end
    if (word_idx == STATUS_IDX) begin
      rd_data = {16'h0, cnt_q};
    end
`endif
  end

  // Transfer FSM: one registered ack per select, then wait for select to drop
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      state  <= ST_IDLE;
      ack_q  <= 1'b0;
      dbus_q <= 32'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          ack_q  <= 1'b0;
          dbus_q <= 32'h0;
          if (start) begin
            state  <= ST_ACK;
            ack_q  <= 1'b1;
            dbus_q <= OPB_RNW ? rd_data : 32'h0;
          end
        end
        ST_ACK: begin
          state  <= ST_HOLD;
          ack_q  <= 1'b0;
          dbus_q <= 32'h0;
        end
        ST_HOLD: begin
          ack_q  <= 1'b0;
          dbus_q <= 32'h0;
          if (!OPB_select) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state  <= ST_IDLE;
          ack_q  <= 1'b0;
          dbus_q <= 32'h0;
        end
      endcase
    end
  end

  // Shadow registers take the enabled byte lanes on the ack edge
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      for (int i = 0; i < C_NUM_REGS; i++) begin
        shadow[i] <= C_RESET_VAL;
      end
    end else begin
      for (int i = 0; i < C_NUM_REGS; i++) begin
        if (wr_start && (word_idx == 30'(i))) begin
          shadow[i] <= (shadow[i] & ~lane_mask) | (wdata & lane_mask);
        end
      end
    end
  end

  // Remember which update is owed so the fabric side changes one edge later
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      commit_pend <= 1'b0;
      auto_mask   <= '0;
    end else begin
      commit_pend <= commit_hit;
      for (int i = 0; i < C_NUM_REGS; i++) begin
        auto_mask[i] <= (C_AUTO_COMMIT != 0) && wr_start && (word_idx == 30'(i));
      end
    end
  end

  // Active registers, load strobe and commit counter on the fabric side
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      active_q <= {C_NUM_REGS{C_RESET_VAL}};
      load_q   <= 1'b0;
      cnt_q    <= 16'h0;
    end else begin
      load_q <= commit_pend | (|auto_mask);
      if (commit_pend) begin
        cnt_q <= cnt_q + 16'd1;
        for (int i = 0; i < C_NUM_REGS; i++) begin
          active_q[32*i +: 32] <= shadow[i];
        end
      end else begin
        for (int i = 0; i < C_NUM_REGS; i++) begin
          if (auto_mask[i]) begin
            active_q[32*i +: 32] <= shadow[i];
          end
        end
      end
    end
  end

  assign Sl_DBus         = dbus_q;
  assign Sl_xferAck      = ack_q;
  assign Sl_errAck       = 1'b0;
  assign Sl_retry        = 1'b0;
  assign Sl_toutSup      = 1'b0;
  assign user_data_out   = active_q;
  assign user_load       = load_q;
  assign user_commit_cnt = cnt_q;

  // Sequential-address hint and the byte offset carry no meaning here
  logic unused_inputs;
  assign unused_inputs = &{1'b0, OPB_seqAddr, offset[1:0]};

endmodule
